// File: rtl/ccip_c0_rd_arb_pkg.sv
// ---------------------------------------------------------------------------
// ccip_c0_rd_arb_pkg : shared CCI-P c0 types, arbiter state and helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ccip_c0_rd_arb_pkg;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef struct packed {
    logic [41:0] address;
    t_ccip_clLen cl_len;
    logic [15:0] mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_rsp resp_type;
    logic [1:0]   cl_num;
    logic [15:0]  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef enum logic [1:0] {
    ARB_RUN   = 2'd0,
    ARB_DRAIN = 2'd1,
    ARB_DONE  = 2'd2
  } t_arb_state;

  localparam int REQ_TAG_BIT = 15;

  function automatic logic [2:0] clLenToLines(input t_ccip_clLen cl_len);
    case (cl_len)
      eCL_LEN_2: return 3'd2;
      eCL_LEN_4: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

  function automatic t_if_ccip_c0_Tx ccip_c0Tx_clearValids(input t_if_ccip_c0_Tx t);
    t_if_ccip_c0_Tx r;
    r       = t;
    r.valid = 1'b0;
    return r;
  endfunction

  function automatic t_if_ccip_c0_Rx ccip_c0Rx_clearValids(input t_if_ccip_c0_Rx t);
    t_if_ccip_c0_Rx r;
    r             = t;
    r.rspValid    = 1'b0;
    r.mmioRdValid = 1'b0;
    r.mmioWrValid = 1'b0;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ccip_c0_rd_arb_rr.sv
// ---------------------------------------------------------------------------
// ccip_rr_arb2 : two-way round-robin arbiter favouring the loser of the last grant
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ccip_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  logic last_q, last_d;

  always_comb begin
    grant_o = req_i;
    if (req_i[0] && req_i[1]) begin
      grant_o = last_q ? 2'b01 : 2'b10;
    end
    last_d = last_q;
    if (grant_o[1]) begin
      last_d = 1'b1;
    end else if (grant_o[0]) begin
      last_d = 1'b0;
    end
  end

  // Reset value marks requester 1 as last winner so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ccip_c0_rd_arb.sv
// ---------------------------------------------------------------------------
// ccip_c0_rd_arb : 2:1 CCI-P c0 read arbiter with line credit and drain control
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ccip_c0_rd_arb
  import ccip_c0_rd_arb_pkg::*;
#(
  parameter int MAX_LINES = 64,
  localparam int CNT_W = $clog2(MAX_LINES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  t_if_ccip_c0_Tx [1:0]  req_c0Tx,
  output logic [1:0]            req_rdy,
  output t_if_ccip_c0_Tx        c0Tx,
  input  logic                  c0TxAlmFull,
  input  t_if_ccip_c0_Rx        c0Rx,
  output t_if_ccip_c0_Rx [1:0]  req_c0Rx,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic [CNT_W-1:0]      outstanding
);

  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_LINES);

  t_arb_state           state_q, state_d;
  logic [CNT_W-1:0]     out_q, out_d;
  t_if_ccip_c0_Tx       c0Tx_q, c0Tx_d;
  t_if_ccip_c0_Rx [1:0] rx_q, rx_d;
  logic                 drain_done_q, drain_done_d;
  logic [1:0][2:0]      req_lines;
  logic [1:0]           eligible;
  logic [1:0]           grant;
  logic                 accept;
  logic                 sel;
  logic                 dec;

  always_comb begin
    req_lines = '0;
    eligible  = '0;
    for (int i = 0; i < 2; i++) begin
      req_lines[i] = clLenToLines(req_c0Tx[i].hdr.cl_len);
      eligible[i]  = !reset && (state_q == ARB_RUN) && !drain_req && !c0TxAlmFull &&
                     req_c0Tx[i].valid &&
                     (({1'b0, out_q} + SUM_W'(req_lines[i])) <= MAX_SUM);
    end
  end

  ccip_rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req_i   (eligible),
    .grant_o (grant)
  );

  assign req_rdy = grant;
  assign accept  = |grant;
  assign sel     = grant[1];
  assign dec     = c0Rx.rspValid && (c0Rx.hdr.resp_type == eRSP_RDLINE);

  // Credit never exceeds MAX_LINES, so CNT_W arithmetic cannot wrap upward.
  always_comb begin
    c0Tx_d = ccip_c0Tx_clearValids(c0Tx_q);
    out_d  = out_q;
    if (accept) begin
      c0Tx_d                         = req_c0Tx[sel];
      c0Tx_d.hdr.mdata[REQ_TAG_BIT]  = sel;
      c0Tx_d.valid                   = 1'b1;
      out_d                          = out_q + CNT_W'(req_lines[sel]);
    end
    if (dec && (out_d != '0)) begin
      out_d = out_d - 1'b1;
    end
  end

  always_comb begin
    rx_d = '0;
    for (int i = 0; i < 2; i++) begin
      rx_d[i] = ccip_c0Rx_clearValids(c0Rx);
      if (c0Rx.rspValid) begin
        rx_d[i].hdr.mdata[REQ_TAG_BIT] = 1'b0;
      end
      rx_d[i].rspValid = c0Rx.rspValid && (c0Rx.hdr.mdata[REQ_TAG_BIT] == 1'(i));
    end
    rx_d[0].mmioRdValid = c0Rx.mmioRdValid;
    rx_d[0].mmioWrValid = c0Rx.mmioWrValid;
  end

  // Quiesce is judged on the next count so drain_done lands with the last response.
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    case (state_q)
      ARB_RUN: begin
        if (drain_req) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (!drain_req) begin
          state_d = ARB_RUN;
        end else if ((out_d == '0) && !c0Tx_q.valid) begin
          state_d      = ARB_DONE;
          drain_done_d = 1'b1;
        end
      end
      ARB_DONE: begin
        if (!drain_req) state_d = ARB_RUN;
      end
      default: state_d = ARB_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_RUN;
      out_q        <= '0;
      c0Tx_q       <= '0;
      rx_q         <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      c0Tx_q       <= c0Tx_d;
      rx_q         <= rx_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign c0Tx        = c0Tx_q;
  assign req_c0Rx    = rx_q;
  assign drain_done  = drain_done_q;
  assign outstanding = out_q;

endmodule

`default_nettype wire

// File: doc/ccip_c0_rd_arb.md
CCIP_C0_RD_ARB -- requirements
Module: ccip_c0_rd_arb

Interface
REQ-001 SHALL have parameter MAX_LINES, 64, max outstanding read lines summed over both requesters (range 4..256).
REQ-002 SHALL have ports in this order: clk  in  1  sole clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_c0Tx  in  2 x t_if_ccip_c0_Tx  per-requester read request; .valid qualifies it.
REQ-005 req_rdy  out  2  request accepted this cycle when req_c0Tx[i].valid && req_rdy[i].
REQ-006 c0Tx  out  t_if_ccip_c0_Tx  arbitrated request to the FIU.
REQ-007 c0TxAlmFull  in  1  FIU almost-full backpressure.
REQ-008 c0Rx  in  t_if_ccip_c0_Rx  FIU response channel.
REQ-009 req_c0Rx  out  2 x t_if_ccip_c0_Rx  per-requester response channel.
REQ-010 drain_req  in  1  level; request quiesce.
REQ-011 drain_done  out  1  one-cycle pulse when quiesced.
REQ-012 outstanding  out  $clog2(MAX_LINES+1)  current outstanding line count.

Function
REQ-013 SHALL compute grants combinationally: req_rdy[i]=1 only when state==RUN, !c0TxAlmFull, req valid, outstanding+lines(req)<=MAX_LINES, and i wins round-robin.
REQ-014 Round-robin SHALL favour the requester not granted last; with one valid requester it SHALL be granted every eligible cycle; at most one req_rdy high per cycle.
REQ-015 lines(req) SHALL be 1/2/4 for cl_len eCL_LEN_1/eCL_LEN_2/eCL_LEN_4.
REQ-016 Accepted request SHALL appear on c0Tx exactly one cycle later (registered), unchanged except mdata[15] := requester index; c0Tx.valid=0 otherwise.
REQ-017 Requesters SHALL keep mdata[15]=0; value presented is ignored and overwritten.
REQ-018 c0Rx with rspValid SHALL be forwarded, registered, one cycle later to req_c0Rx[c0Rx.hdr.mdata[15]] with mdata[15] cleared; the other port's rspValid=0.
REQ-019 c0Rx mmioRdValid/mmioWrValid SHALL be forwarded, registered, to req_c0Rx[0] only; req_c0Rx[1] mmio valids always 0.
REQ-020 Each rspValid with resp_type eRSP_RDLINE SHALL decrement outstanding by 1; other rsp types SHALL not change it.
REQ-021 Accept and decrement in same cycle SHALL update outstanding by lines(req)-1 in one step.
REQ-022 Decrement at outstanding==0 (protocol error) SHALL saturate at 0.
REQ-023 States: RUN, DRAIN, DONE; RUN->DRAIN when drain_req; DRAIN->DONE when outstanding==0 and no c0Tx pending; DONE pulses drain_done for one cycle, then ->RUN if !drain_req else stays DRAIN-held in DONE (no pulse repeat) until drain_req falls.
REQ-024 In DRAIN and DONE all req_rdy SHALL be 0; responses SHALL still be routed.
REQ-025 drain_req deasserted during DRAIN SHALL return to RUN next cycle without drain_done.

Reset
REQ-026 On reset: state=RUN, outstanding=0, RR pointer favours requester 0, c0Tx.valid=0, all req_c0Rx valids=0, drain_done=0, req_rdy=0 during reset cycle.
REQ-027 Reset mid-operation SHALL discard in-flight counts; responses arriving afterwards are routed but counted per REQ-022.
REQ-028 Non-valid struct fields SHALL use ccip_c0Tx_clearValids/ccip_c0Rx_clearValids.

Structure
REQ-029 Shared package ccip_c0_rd_arb_pkg SHALL hold t_arb_state enum, REQ_TAG_BIT=15, and function clLenToLines.
REQ-030 Round-robin arbiter SHALL be sub-module ccip_rr_arb2 (2 requests, grant, last-grant register).

Verification
REQ-031 Both requesters valid continuously, cl_len 1, no almFull -> grants alternate 0,1,0,1; c0Tx mdata[15] alternates 0,1.
REQ-032 MAX_LINES=4, requester 0 issues eCL_LEN_4 then eCL_LEN_1 -> second blocked (outstanding=4) until one RDLINE response, then granted.
REQ-033 c0TxAlmFull=1 for 5 cycles -> req_rdy=0 throughout, no c0Tx.valid one cycle after deassert clears.
REQ-034 Response mdata=16'h8005 -> req_c0Rx[1] rspValid with mdata 16'h0005 one cycle later; req_c0Rx[0] idle.
REQ-035 outstanding=3, accept eCL_LEN_2 and RDLINE response same cycle -> outstanding=4.
REQ-036 drain_req with 3 outstanding -> req_rdy=0 immediately; drain_done pulses one cycle after third response; reset mid-drain -> RUN, outstanding=0.
